// File: rtl/kisc_alu_if.sv
// Operand/result bundle between the KISC-V execute stage and kisc_alu.
// The core drives op/a/b/en (master); the ALU returns y/cmp and their registered copies (slave).
interface kisc_alu_if;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        en;
    logic [31:0] y;
    logic        cmp;
    logic [31:0] y_q;
    logic        cmp_q;

    modport master (
        output op, a, b, en,
        input  y, cmp, y_q, cmp_q
    );

    modport slave (
        input  op, a, b, en,
        output y, cmp, y_q, cmp_q
    );
endinterface

// File: rtl/kisc_alu.sv
// Single-cycle RV32I ALU with parallel branch compare for the KISC-V core.
// Optional registered outputs are built when ALU_OUT_REG_EN is defined; otherwise y_q/cmp_q mirror y/cmp.
module kisc_alu (
    input logic       clk,
    input logic       rts_n,
    kisc_alu_if.slave bus
);
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    function automatic logic signed_lt(input logic [31:0] x, input logic [31:0] z);
        return $signed(x) < $signed(z);
    endfunction

    logic [4:0]  shamt_s;
    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [31:0] sra_s;
    logic        lt_s;
    logic        ltu_s;
    logic        eq_s;
    logic [31:0] y_s;
    logic        cmp_s;

    assign shamt_s = bus.b[4:0];
    assign sum_s   = bus.a + bus.b;
    assign diff_s  = bus.a - bus.b;
    assign sra_s   = $signed(bus.a) >>> shamt_s;
    assign lt_s    = signed_lt(bus.a, bus.b);
    assign ltu_s   = (bus.a < bus.b);
    assign eq_s    = (bus.a == bus.b);

    // Result mux: ex only distinguishes ADD/SUB and SRL/SRA.
    always_comb begin
        y_s = 32'h0000_0000;
        case (bus.op[2:0])
            F3_ADD: begin
                if (bus.op[3]) y_s = diff_s;
                else           y_s = sum_s;
            end
            F3_SLL:  y_s = bus.a << shamt_s;
            F3_SLT:  y_s = {31'h0000_0000, lt_s};
            F3_SLTU: y_s = {31'h0000_0000, ltu_s};
            F3_XOR:  y_s = bus.a ^ bus.b;
            F3_SR: begin
                if (bus.op[3]) y_s = sra_s;
                else           y_s = bus.a >> shamt_s;
            end
            F3_OR:   y_s = bus.a | bus.b;
            F3_AND:  y_s = bus.a & bus.b;
            default: y_s = 32'h0000_0000;
        endcase
    end

    // Branch compare: ex is an immediate bit during branches, so it never participates.
    always_comb begin
        cmp_s = 1'b0;
        case (bus.op[2:0])
            3'b000:  cmp_s = eq_s;
            3'b001:  cmp_s = ~eq_s;
            3'b100:  cmp_s = lt_s;
            3'b101:  cmp_s = ~lt_s;
            3'b110:  cmp_s = ltu_s;
            3'b111:  cmp_s = ~ltu_s;
            default: cmp_s = 1'b0;
        endcase
    end

    assign bus.y   = y_s;
    assign bus.cmp = cmp_s;

`ifdef ALU_OUT_REG_EN
    logic [31:0] y_q_r;
    logic        cmp_q_r;

    // Capture register: reset dominates the enable.
    always_ff @(posedge clk) begin
        if (!rts_n) begin
            y_q_r   <= 32'h0000_0000;
            cmp_q_r <= 1'b0;
        end else if (bus.en) begin
            y_q_r   <= y_s;
            cmp_q_r <= cmp_s;
        end
    end

    assign bus.y_q   = y_q_r;
    assign bus.cmp_q = cmp_q_r;
`else
    logic unused_s;
    assign unused_s  = &{1'b0, clk, rts_n, bus.en};
    assign bus.y_q   = y_s;
    assign bus.cmp_q = cmp_s;
`endif
endmodule

// File: tb/tb_kisc_alu.sv
// Scoreboard bench for kisc_alu: directed ALU/compare vectors plus either the
// registered-path sequence (ALU_OUT_REG_EN) or a random pass-through sweep.
module tb_kisc_alu;
    logic clk;
    logic rts_n;
    int   checks;
    int   errors;

    typedef struct {
        logic [31:0] y;
        logic        cmp;
    } exp_t;

    exp_t sb[$];

    kisc_alu_if bus ();

    kisc_alu dut (
        .clk   (clk),
        .rts_n (rts_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: subtraction via two's complement, signed order via sign flip, shifts via loops.
    function automatic logic [31:0] ref_y(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int          n;
        n = int'(b[4:0]);
        r = 32'h0000_0000;
        case (op[2:0])
            3'b000: r = op[3] ? (a + ~b + 32'h0000_0001) : (a + b);
            3'b001: begin
                r = a;
                for (int i = 0; i < n; i++) r = {r[30:0], 1'b0};
            end
            3'b010: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'h0000_0001 : 32'h0000_0000;
            3'b011: r = (a < b) ? 32'h0000_0001 : 32'h0000_0000;
            3'b100: r = a ^ b;
            3'b101: begin
                r = a;
                for (int i = 0; i < n; i++) r = {(op[3] & a[31]), r[31:1]};
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic ref_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic slt;
        slt = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
        case (op[2:0])
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return slt;
            3'b101:  return !slt;
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
    endtask

    task automatic test_add_sub();
        logic [3:0]  ops[4] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000};
        logic [31:0] as[4]  = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] bs[4]  = '{32'd7, 32'd5, 32'd1, 32'd1};
        logic [31:0] ys[4]  = '{32'h0000_000C, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            apply(ops[i], as[i], bs[i]);
            sb.push_back('{y: ys[i], cmp: 1'b0});
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.y !== e.y) begin
                errors++;
                $display("FAIL add_sub[%0d] y got %h expected %h", i, bus.y, e.y);
            end
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops[6] = '{4'b0101, 4'b1101, 4'b0001, 4'b1101, 4'b0001, 4'b1001};
        logic [31:0] as[6]  = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1, 32'd1};
        logic [31:0] bs[6]  = '{32'h24, 32'h24, 32'h24, 32'd31, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ys[6]  = '{32'h0800_0000, 32'hF800_0000, 32'h0000_0010,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            apply(ops[i], as[i], bs[i]);
            sb.push_back('{y: ys[i], cmp: 1'b0});
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.y !== e.y) begin
                errors++;
                $display("FAIL shifts[%0d] y got %h expected %h", i, bus.y, e.y);
            end
        end
    endtask

    task automatic test_slt_logic();
        logic [3:0]  ops[8] = '{4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b1010, 4'b0100, 4'b1110, 4'b0111};
        logic [31:0] as[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'hFFFF_FFFF,
                                32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
        logic [31:0] bs[8]  = '{32'd1, 32'd1, 32'd7, 32'd7, 32'd1,
                                32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00};
        logic [31:0] ys[8]  = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1,
                                32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'hF000_F000};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            apply(ops[i], as[i], bs[i]);
            sb.push_back('{y: ys[i], cmp: 1'b0});
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.y !== e.y) begin
                errors++;
                $display("FAIL slt_logic[%0d] y got %h expected %h", i, bus.y, e.y);
            end
        end
    endtask

    task automatic test_compares();
        logic [3:0]  ops[9] = '{4'b0000, 4'b0001, 4'b1101, 4'b0111, 4'b0100, 4'b0110, 4'b0010, 4'b1011, 4'b1000};
        logic [31:0] as[9]  = '{32'h1234, 32'h1234, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                32'hFFFF_FFFE, 32'd1, 32'd1, 32'h1234};
        logic [31:0] bs[9]  = '{32'h1234, 32'h1234, 32'd2, 32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'h1234};
        logic        cs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            apply(ops[i], as[i], bs[i]);
            sb.push_back('{y: 32'h0, cmp: cs[i]});
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.cmp !== e.cmp) begin
                errors++;
                $display("FAIL compares[%0d] cmp got %b expected %b", i, bus.cmp, e.cmp);
            end
        end
    endtask

`ifdef ALU_OUT_REG_EN
    // Each step: drive at negedge, push the expected register contents, check after the next posedge.
    task automatic test_registered();
        logic        rs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        ens[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0]  ops[5] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        logic [31:0] as[5]  = '{32'd5, 32'd5, 32'd9, 32'd3, 32'd3};
        logic [31:0] bs[5]  = '{32'd7, 32'd7, 32'd1, 32'd3, 32'd3};
        logic [31:0] yq[5]  = '{32'd0, 32'd12, 32'd12, 32'd6, 32'd0};
        logic        cq[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] yc[5]  = '{32'd12, 32'd12, 32'd8, 32'd6, 32'd6};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rts_n  = rs[i];
            bus.en = ens[i];
            apply(ops[i], as[i], bs[i]);
            sb.push_back('{y: yq[i], cmp: cq[i]});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.y_q !== e.y || bus.cmp_q !== e.cmp) begin
                errors++;
                $display("FAIL registered[%0d] y_q/cmp_q got %h/%b expected %h/%b",
                         i, bus.y_q, bus.cmp_q, e.y, e.cmp);
            end
            checks++;
            if (bus.y !== yc[i]) begin
                errors++;
                $display("FAIL registered_comb[%0d] y got %h expected %h", i, bus.y, yc[i]);
            end
        end
        rts_n = 1'b1;
    endtask
`else
    task automatic test_comb_random();
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          bad;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            apply(op, a, b);
            sb.push_back('{y: ref_y(op, a, b), cmp: ref_cmp(op, a, b)});
            #1;
            e = sb.pop_front();
            checks++;
            if (bus.y !== e.y || bus.cmp !== e.cmp || bus.y_q !== e.y || bus.cmp_q !== e.cmp) begin
                errors++;
                if (bad < 10)
                    $display("FAIL comb_random[%0d] op=%b a=%h b=%h y/cmp/y_q/cmp_q got %h/%b/%h/%b expected %h/%b",
                             i, op, a, b, bus.y, bus.cmp, bus.y_q, bus.cmp_q, e.y, e.cmp);
                bad++;
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rts_n  = 1'b1;
        bus.en = 1'b0;
        apply(4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        test_add_sub();
        test_shifts();
        test_slt_logic();
        test_compares();
`ifdef ALU_OUT_REG_EN
        test_registered();
`else
        test_comb_random();
`endif
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain leftover got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kisc_alu.md
# kisc_alu

Single-cycle 32-bit integer ALU for the KISC-V core; the RTL module is named `kisc_alu`. It evaluates RV32I register/immediate arithmetic, logic, shift and set-less-than operations and, in parallel, the six RV32I branch comparisons. The core drives it from the decoded instruction (`{instr[30] qualifier, funct3}`, rs1, rs2/immediate) and consumes the combinational result in the same cycle. An optional registered copy of result and compare flag is provided for pipelined or debug consumers.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` in 1: single clock; all sequential logic on rising edge.
- `rts_n` in 1: reset, synchronous, active-low.
- `op` in 4: `{ex, funct3}`; `ex` selects SUB/SRA.
- `a` in 32: operand A (rs1).
- `b` in 32: operand B (rs2 or sign-extended immediate).
- `en` in 1: capture enable for registered outputs.
- `y` out 32: combinational result.
- `cmp` out 1: combinational branch-compare flag.
- `y_q` out 32: registered result.
- `cmp_q` out 1: registered compare flag.

## Operation
- `y` by `op`:
  - 0000 `a+b`; 1000 `a-b` (mod 2^32).
  - x001 `a << b[4:0]`.
  - x010 signed `a<b` → 1 else 0.
  - x011 unsigned `a<b` → 1 else 0.
  - x100 `a^b`.
  - 0101 logical `a >> b[4:0]`; 1101 arithmetic (sign-filled).
  - x110 `a|b`; x111 `a&b`.
- `ex` is ignored except for funct3 000 and 101. `b[31:5]` is ignored for shifts.
- `cmp` uses `op[2:0]` only; `ex` is ignored because the core drives it from an immediate bit during branches:
  - 000 `a==b`; 001 `a!=b`.
  - 100 signed `a<b`; 101 signed `a>=b`.
  - 110 unsigned `a<b`; 111 unsigned `a>=b`.
  - 010/011 → 0.
- `y` and `cmp` are computed every cycle regardless of instruction class. The consumer decides which to use.
- No overflow, carry or exception outputs; all arithmetic wraps.

## Timing
- `y` and `cmp` are purely combinational: zero latency, valid in the same cycle the inputs settle. The core depends on this.
- Registered path, with `ALU_OUT_REG_EN`:
  - Rising edge with `rts_n`=0: `y_q`←0, `cmp_q`←0. Reset wins over `en`.
  - Else with `en`=1: `y_q`←`y`, `cmp_q`←`cmp`. One-cycle latency.
  - Else: hold.
- Reset mid-operation affects only the registers; the combinational outputs keep tracking the inputs.
- No handshake and no state machine.

## Configuration
- `ALU_OUT_REG_EN` defined: `y_q`/`cmp_q` are flops per Timing.
- Undefined: `y_q`=`y` and `cmp_q`=`cmp` combinationally; `clk`, `rts_n` and `en` are unused and no flops are inferred.

## Test plan
- Add/sub: `op`=0000, a=5, b=7 → y=0x0000000C; `op`=1000, a=3, b=5 → y=0xFFFFFFFE; a=0xFFFFFFFF, b=1, add → y=0.
- Shifts: a=0x80000000, b=0x24 → 0101 y=0x08000000; 1101 y=0xF8000000; 0001 with a=1 → y=0x00000010.
- SLT: a=0xFFFFFFFF, b=1 → 0010 y=1; 0011 y=0. Equal operands → both 0.
- Compares: a=b=0x1234 → 000 cmp=1, 001 cmp=0. a=0xFFFFFFFE, b=2 → 1101 cmp=0 (signed ge, `ex` ignored), 0111 cmp=1.
- Registered path (macro on): hold `rts_n`=0 one edge → y_q=0, cmp_q=0. Release, en=1, add 5+7 → y_q=12 after the next edge. en=0 with changed inputs → y_q holds 12. Assert `rts_n`=0 with en=1 → y_q=0.
- Macro off: y_q tracks y within the same cycle for random op/a/b; compare against a reference model over 10k vectors.
